// File: rtl/write_collision_pkg.sv
// Shared constants and helpers for the per-cell write-collision arbiter.
package write_collision_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest hit vector the helper below accepts; callers zero-extend.
  localparam int unsigned MAX_AGENTS = 64;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  function automatic logic popcount_ge2(input logic [MAX_AGENTS-1:0] hit);
    return (hit & (hit - MAX_AGENTS'(1))) != '0;
  endfunction

  // Pointer width for n agents; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/write_prio_encoder.sv
// Rotating priority encoder: first set request at or above start, wrapping.
// Duplicating the request vector and masking the lower copy below start
// turns the wrap-around search into a plain lowest-bit-first search.
module write_prio_encoder
  import write_collision_pkg::*;
#(
  parameter int unsigned NB_WRAGENT = 4,
  localparam int unsigned PTR_W = clog2_min1(NB_WRAGENT)
) (
  input  logic [NB_WRAGENT-1:0] req,
  input  logic [PTR_W-1:0]      start,
  output logic [NB_WRAGENT-1:0] grant,
  output logic [PTR_W-1:0]      index
);

  localparam int unsigned DW = 2 * NB_WRAGENT;

  logic [DW-1:0] masked;
  logic          any;
  int unsigned   win;

  // Double-width request with bits below the start pointer removed.
  always_comb begin
    for (int unsigned i = 0; i < DW; i++) begin
      if (i < NB_WRAGENT) masked[i] = req[i] && (i >= 32'(start));
      else                masked[i] = req[i - NB_WRAGENT];
    end
  end

  // Lowest set bit of the masked vector, folded back to an agent index.
  always_comb begin
    any = 1'b0;
    win = 0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (!any && masked[i]) begin
        any = 1'b1;
        win = (i >= NB_WRAGENT) ? i - NB_WRAGENT : i;
      end
    end
  end

  // One-hot form of the winner; all zero when nothing is requested.
  always_comb begin
    for (int unsigned j = 0; j < NB_WRAGENT; j++) begin
      grant[j] = any && (win == j);
    end
  end

  assign index = PTR_W'(win);

endmodule

// File: rtl/write_collision_arbiter.sv
// Per-cell write-collision detector/resolver with registered one-hot grant,
// saturating collision counter and sticky debug flag.
module write_collision_arbiter
  import write_collision_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NB_WRAGENT = 4,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_WIDTH-1:0]            cell_addr,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic                             clear,
  output logic [NB_WRAGENT-1:0]            wrgrant,
  output logic                             collision,
  output logic [CNT_WIDTH-1:0]             collision_cnt,
  output logic                             collision_sticky
);

  localparam int unsigned PTR_W = clog2_min1(NB_WRAGENT);

  logic [NB_WRAGENT-1:0] hit;
  logic [NB_WRAGENT-1:0] win_gnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      start_ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  coll_c;

  // Agents whose enabled write targets this cell.
  always_comb begin
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      hit[i] = wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == cell_addr);
    end
  end

  assign coll_c    = popcount_ge2(MAX_AGENTS'(hit));
  assign start_ptr = (PRIO_MODE == PRIO_RR) ? rr_ptr : '0;
  assign next_ptr  = (32'(win_idx) == NB_WRAGENT - 1) ? '0 : win_idx + 1'b1;

  write_prio_encoder #(
    .NB_WRAGENT(NB_WRAGENT)
  ) u_prio (
    .req  (hit),
    .start(start_ptr),
    .grant(win_gnt),
    .index(win_idx)
  );

  // Output registers, round-robin pointer, counter and sticky flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrgrant          <= '0;
      collision        <= 1'b0;
      collision_cnt    <= '0;
      collision_sticky <= 1'b0;
      rr_ptr           <= '0;
    end else begin
      wrgrant   <= win_gnt;
      collision <= coll_c;
      if (PRIO_MODE == PRIO_RR && coll_c) rr_ptr <= next_ptr;
      // clear wins over history but never swallows a same-cycle collision
      if (clear) begin
        collision_cnt    <= coll_c ? CNT_WIDTH'(1) : '0;
        collision_sticky <= coll_c;
      end else begin
        if (coll_c && collision_cnt != '1) collision_cnt <= collision_cnt + 1'b1;
        if (coll_c) collision_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: doc/write_collision_arbiter.md
Name: write_collision_arbiter

Overview:
Per-cell write-collision detector and resolver for the multi-port RAM.
- Monitors NB_WRAGENT write agents against one cell address.
- Flags a collision when any two or more agents write that cell in the same cycle, not only when all agents do.
- Picks a single winning agent, using a fixed or round-robin priority mode, and keeps a saturating collision counter and a sticky status flag for debug.
- Sits beside each RAM cell/bank; the write mux consumes the registered grant vector.

Parameters:
ADDR_WIDTH, 8, write address width.
NB_WRAGENT, 4, number of write agents; legal range >= 1, need not be a power of 2.
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
CNT_WIDTH, 16, width of the collision event counter.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, asynchronous, active-low.
cell_addr  in  ADDR_WIDTH  address of the monitored cell.
wren  in  NB_WRAGENT  per-agent write enable.
wraddr  in  NB_WRAGENT*ADDR_WIDTH  packed write addresses; agent i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
clear  in  1  synchronous clear of collision_cnt and collision_sticky.
wrgrant  out  NB_WRAGENT  registered one-hot grant of the winning agent (all zero when no hit).
collision  out  1  registered; asserted when at least 2 agents hit the cell.
collision_cnt  out  CNT_WIDTH  number of collision cycles, saturating.
collision_sticky  out  1  set by any collision; held until clear.

Behaviour:
- Hit vector: hit[i] = wren[i] & (wraddr slice i == cell_addr). This is combinational.
- Collision condition: coll_c = popcount(hit) >= 2.
- Winner, fixed mode: the lowest-index set bit of hit.
- Winner, round-robin mode: the first set bit of hit, searching upward from rr_ptr and wrapping from NB_WRAGENT-1 to 0.
- rr_ptr width: clog2(NB_WRAGENT), minimum 1. Reset value is 0.
- rr_ptr update: only on cycles where coll_c = 1. It loads winner+1, wrapping NB_WRAGENT-1 -> 0 for any N. A single uncontended hit does not move rr_ptr. In fixed mode rr_ptr is unused and held at 0.
- Latency: 1 cycle. wrgrant and collision register the cycle-t comb results and are visible at t+1.
- wrgrant with exactly 1 hit is that agent's one-hot. With 0 hits it is all zero.
- collision_cnt: increments by 1 on each cycle coll_c = 1 and saturates at all-ones, with no wrap.
- collision_sticky: set on coll_c = 1.
- clear in the same cycle as coll_c: the current event is kept, so the cycle is never lost.
  - collision_cnt <= (coll_c ? 1 : 0).
  - collision_sticky <= coll_c.
- Reset: asynchronous assertion drives wrgrant = 0, collision = 0, collision_cnt = 0, collision_sticky = 0, rr_ptr = 0. Reset mid-collision discards the pending grant. The first cycle after deassertion behaves as fresh.
- NB_WRAGENT = 1: collision is constantly 0, the counter stays 0, and wrgrant = registered hit.
- Agents writing other addresses never affect grant or collision, even if enabled.
- Outputs change only on the aclk rising edge, except for the asynchronous reset.

Decomposition:
- Package write_collision_pkg holds:
  - PRIO_FIXED = 0 and PRIO_RR = 1 constants.
  - A popcount_ge2 function on a hit vector.
  - A clog2-min-1 helper for pointer width.
- Sub-module write_prio_encoder:
  - Combinational, parameter NB_WRAGENT.
  - Inputs: request vector and start pointer.
  - Output: one-hot grant plus binary index of the winner.
  - Implemented as double-width mask-and-fixed-priority.
  - Fixed mode instantiates it with the start pointer tied to 0.
- The top holds the hit compare, the output registers, rr_ptr, the counter and the sticky flag.

Test Plan:
All tests use NB_WRAGENT = 4, ADDR_WIDTH = 8, CNT_WIDTH = 4, cell_addr = 0x3C.
1. Single hit: wren = 0100, agent2 addr = 0x3C, others 0x00 -> next cycle wrgrant = 0100, collision = 0, collision_cnt = 0. Agents with wren = 1 at another address -> wrgrant = 0000.
2. Fixed mode: wren = 1111, agents 1 and 3 at 0x3C -> next cycle wrgrant = 0010, collision = 1, cnt = 1, sticky = 1. The old all-agents check would not fire here.
3. Round-robin: agents 0, 1, 3 hit the cell for 4 consecutive cycles -> grants 0001, 0010, 1000, 0001. rr_ptr wraps 3 -> 0 correctly.
4. Saturation and clear: 20 consecutive collision cycles -> cnt holds at 0xF. clear with no collision -> cnt = 0, sticky = 0. clear together with a collision -> cnt = 1, sticky = 1.
5. Reset mid-operation: assert aresetn = 0 asynchronously between edges during a collision burst -> all outputs 0 immediately. After release, a single hit from agent 0 -> wrgrant = 0001 and the RR search restarts from 0.
6. NB_WRAGENT = 3 in round-robin mode: all agents hit for 6 cycles -> grants cycle 001, 010, 100, with no out-of-range pointer value.
